front_panel_ctrl: RTL

Synthesizable PDP-8 front-panel command responder inside `Top`, between the board switches/buttons and the CPU/memory. It synchronizes and debounces the panel buttons and turns each press into one operation:
- deposit a switch word into memory at the panel address, then auto-increment;
- load PC or AC from the switches;
- single-step.

It is the responder to the bench/operator sequence of setting `sw[11:0]`, pulsing a button and waiting ≥10 cycles.

---
 rtl/front_panel_ctrl_pkg.sv | 13 +
 rtl/front_panel_ctrl_debounce.sv | 50 +++++
 rtl/front_panel_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/front_panel_ctrl_pkg.sv
// Shared types and constants for the PDP-8 front-panel responder.
package front_panel_ctrl_pkg;
    localparam int WORD_W           = 12;
    localparam int DEBOUNCE_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_LDPC,
        ST_LDAC,
        ST_STEP
    } fp_state_t;
endpackage

// File: rtl/front_panel_ctrl_debounce.sv
// Two-flop synchronizer, down-counting debounce timer, accepted level and rise pulse
// for one raw panel input.
module fp_debounce
    import front_panel_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);
    localparam logic [3:0] CNT_LOAD = 4'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_level_d;

    // The timer reloads whenever the synchronized sample agrees with the accepted level,
    // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips the level.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= CNT_LOAD;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 != r_level) begin
                if (r_cnt == 4'd0) begin
                    r_level <= r_sync2;
                    r_cnt   <= CNT_LOAD;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end else begin
                r_cnt <= CNT_LOAD;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;
endmodule

// File: rtl/front_panel_ctrl.sv
// PDP-8 front-panel command responder: debounced buttons become deposit, load PC/AC and step.
// IDLE wait for press | WR memory write handshake | LDPC pc_load pulse | LDAC ac_load pulse | STEP step_pulse
module front_panel_ctrl
    import front_panel_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [12:0]       i_sw,
    input  logic              i_btn_deposit,
    input  logic              i_btn_load_pc,
    input  logic              i_btn_load_ac,
    input  logic              i_btn_step,
    input  logic              i_cpu_halted,
    output logic              o_mem_wr_req,
    output logic [WORD_W-1:0] o_mem_wr_addr,
    output logic [WORD_W-1:0] o_mem_wr_data,
    input  logic              i_mem_wr_ack,
    output logic              o_pc_load,
    output logic [WORD_W-1:0] o_pc_value,
    output logic              o_ac_load,
    output logic [WORD_W-1:0] o_ac_value,
    output logic              o_step_pulse,
    output logic              o_run_en,
    output logic [WORD_W-1:0] o_fp_addr,
    output logic              o_busy
);
    fp_state_t         r_state;
    fp_state_t         w_state_nxt;
    logic [WORD_W-1:0] r_sw_s1;
    logic [WORD_W-1:0] r_sw_s2;
    logic [WORD_W-1:0] r_fp_addr;
    logic [WORD_W-1:0] r_wr_addr;
    logic [WORD_W-1:0] r_wr_data;
    logic [WORD_W-1:0] r_pc_value;
    logic [WORD_W-1:0] r_ac_value;
    logic [4:0]        w_raw;
    logic [4:0]        w_level;
    logic [4:0]        w_rise;
    logic              w_unused;
    logic              w_cmd_ok;
    logic              w_go_pc;
    logic              w_go_dep;
    logic              w_go_ac;
    logic              w_go_step;

    assign w_raw = {i_sw[12], i_btn_step, i_btn_load_ac, i_btn_load_pc, i_btn_deposit};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        fp_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    // Buttons only need their rise pulse; the run switch only needs its level.
    assign w_unused = ^{w_rise[4], w_level[3:0]};

    assign o_run_en  = w_level[4];
    assign w_cmd_ok  = ~(w_level[4] & ~i_cpu_halted);
    assign w_go_pc   = w_cmd_ok & w_rise[1];
    assign w_go_dep  = w_cmd_ok & w_rise[0] & ~w_rise[1];
    assign w_go_ac   = w_cmd_ok & w_rise[2] & ~w_rise[1] & ~w_rise[0];
    assign w_go_step = w_cmd_ok & w_rise[3] & ~w_rise[2] & ~w_rise[1] & ~w_rise[0] & i_cpu_halted;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if      (w_go_pc)   w_state_nxt = ST_LDPC;
                else if (w_go_dep)  w_state_nxt = ST_WR;
                else if (w_go_ac)   w_state_nxt = ST_LDAC;
                else if (w_go_step) w_state_nxt = ST_STEP;
            end
            ST_WR:   if (i_mem_wr_ack) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_mem_wr_req = 1'b0;
        o_pc_load    = 1'b0;
        o_ac_load    = 1'b0;
        o_step_pulse = 1'b0;
        case (r_state)
            ST_WR:   o_mem_wr_req = 1'b1;
            ST_LDPC: o_pc_load    = 1'b1;
            ST_LDAC: o_ac_load    = 1'b1;
            ST_STEP: o_step_pulse = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sw_s1    <= '0;
            r_sw_s2    <= '0;
            r_fp_addr  <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_pc_value <= '0;
            r_ac_value <= '0;
        end else begin
            r_sw_s1 <= i_sw[WORD_W-1:0];
            r_sw_s2 <= r_sw_s1;
            if (r_state == ST_IDLE) begin
                if (w_go_pc) begin
                    r_fp_addr  <= r_sw_s2;
                    r_pc_value <= r_sw_s2;
                end else if (w_go_dep) begin
                    r_wr_addr <= r_fp_addr;
                    r_wr_data <= r_sw_s2;
                end else if (w_go_ac) begin
                    r_ac_value <= r_sw_s2;
                end
            end
            if (r_state == ST_WR && i_mem_wr_ack)
                r_fp_addr <= r_fp_addr + 12'd1;
        end
    end

    assign o_mem_wr_addr = r_wr_addr;
    assign o_mem_wr_data = r_wr_data;
    assign o_pc_value    = r_pc_value;
    assign o_ac_value    = r_ac_value;
    assign o_fp_addr     = r_fp_addr;
    assign o_busy        = (r_state != ST_IDLE);
endmodule
